// File: rtl/lu_sequencer.sv
// lu_sequencer: command FIFO feeding an external logic unit,
// with a registered result stage and completion counter.
module lu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] lu_a,
    output logic [15:0] lu_b,
    output logic        lu_s1,
    output logic        lu_s2,
    output logic        lu_s3,
    input  logic [15:0] lu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_op,
    output logic        out_zero,
    output logic        out_neg,
    output logic        out_par,
    output logic [15:0] done_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [2:0]    fifo_op [DEPTH];
    logic [15:0]   fifo_a  [DEPTH];
    logic [15:0]   fifo_b  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [2:0]    head_op;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && (!out_valid || out_ready);
    assign head_op  = fifo_op[rd_ptr];

    // Present the head command to the logic unit, zeros when idle
    always_comb begin
        lu_a  = '0;
        lu_b  = '0;
        lu_s1 = 1'b0;
        lu_s2 = 1'b0;
        lu_s3 = 1'b0;
        if (!empty) begin
            lu_a  = fifo_a[rd_ptr];
            lu_b  = fifo_b[rd_ptr];
            lu_s1 = head_op[2];
            lu_s2 = head_op[1];
            lu_s3 = head_op[0];
        end
    end

    // Command storage: written at the tail on accept
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr] <= in_op;
            fifo_a[wr_ptr]  <= in_a;
            fifo_b[wr_ptr]  <= in_b;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Result stage: capture on pop, drop valid when consumed and idle
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_par   <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= lu_out;
            out_op    <= head_op;
            out_zero  <= (lu_out == '0);
            out_neg   <= lu_out[15];
            out_par   <= ^lu_out;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Completion counter, wraps at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lu_sequencer.sv
// tb_lu_sequencer: scoreboard bench with a behavioural logic
// unit, random traffic, and directed corner cases.
module tb_lu_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] lu_a;
    logic [15:0] lu_b;
    logic        lu_s1;
    logic        lu_s2;
    logic        lu_s3;
    logic [15:0] lu_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_op;
    logic        out_zero;
    logic        out_neg;
    logic        out_par;
    logic [15:0] done_cnt;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   acc   = 0;
    int   mdone = 0;

    lu_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .lu_a(lu_a), .lu_b(lu_b),
        .lu_s1(lu_s1), .lu_s2(lu_s2), .lu_s3(lu_s3),
        .lu_out(lu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_op(out_op),
        .out_zero(out_zero), .out_neg(out_neg),
        .out_par(out_par), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lu_f(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return 16'd0 - a;
        endcase
    endfunction

    // Downstream logic unit
    always_comb lu_out = lu_f({lu_s1, lu_s2, lu_s3}, lu_a, lu_b);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record accepted commands with their expected result
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            e.op = in_op;
            e.d  = lu_f(in_op, in_a, in_b);
            exp_q.push_back(e);
            acc++;
        end
    end

    // Monitor: compare presented results against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mdone = 0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stale: got %0h expected none", out_data);
            end else begin
                e = exp_q[0];
                chk("data", {16'd0, out_data}, {16'd0, e.d});
                chk("op", {29'd0, out_op}, {29'd0, e.op});
                chk("zero", {31'd0, out_zero}, {31'd0, e.d == 16'd0});
                chk("neg", {31'd0, out_neg}, {31'd0, e.d[15]});
                chk("par", {31'd0, out_par},
                    32'($countones(e.d) % 2));
                if (out_ready) begin
                    chk("done_cnt", {16'd0, done_cnt},
                        32'(mdone % 65536));
                    mdone++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++)
            tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        int first;
        int last;
        int nv;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        do_reset();

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_flags", {29'd0, out_zero, out_neg, out_par}, 32'd0);
        chk("rst_done", {16'd0, done_cnt}, 32'd0);
        chk("rst_lu", {lu_a, lu_b}, 32'd0);

        out_ready = 1'b1;
        send(3'b000, 16'hFCC3, 16'hCFCC);
        tick();
        in_valid = 1'b0;
        chk("lat_n", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_n1", {31'd0, out_valid}, 32'd1);
        chk("and_data", {16'd0, out_data}, 32'h0000CCC0);
        chk("and_flags", {29'd0, out_zero, out_neg, out_par}, 32'b010);
        tick();

        send(3'b111, 16'h0001, 16'h5555);
        tick();
        send(3'b010, 16'h1234, 16'h1234);
        tick();
        in_valid = 1'b0;
        chk("neg_data", {16'd0, out_data}, 32'h0000FFFF);
        chk("neg_flags", {29'd0, out_zero, out_neg, out_par}, 32'b010);
        tick();
        chk("xor_data", {16'd0, out_data}, 32'd0);
        chk("xor_zero", {31'd0, out_zero}, 32'd1);
        drain();

        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(3'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        in_valid = 1'b0;
        chk("fill_acc", 32'(acc), 32'd5);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_run", {31'd0, out_valid}, 32'd1);
            tick();
        end
        chk("drain_end", {31'd0, out_valid}, 32'd0);

        do_reset();
        out_ready = 1'b1;
        first = -1;
        last  = -1;
        nv    = 0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) begin
                nv++;
                if (first < 0) first = i;
                last = i;
            end
            if (i < 8) send(3'($urandom), 16'($urandom), 16'($urandom));
            else in_valid = 1'b0;
            tick();
        end
        chk("b2b_count", 32'(nv), 32'd8);
        chk("b2b_run", 32'(last - first + 1), 32'd8);
        chk("b2b_done", {16'd0, done_cnt}, 32'd8);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(3'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_done", {16'd0, done_cnt}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0)
                send(3'($urandom), 16'($urandom), 16'($urandom));
            else
                in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        do_reset();
        out_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 70000 && acc < 65536; i++) begin
            send(3'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_acc", 32'(acc), 32'd65536);
        drain();
        chk("wrap_total", 32'(mdone), 32'd65536);
        chk("wrap_cnt", {16'd0, done_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
